// File: rtl/mul_operand_sequencer_pkg.sv
// Shared types and sizing helpers for the multiplier operand sequencer.
package mul_pkg;

    localparam int MUL_W = 16;

    typedef enum logic [2:0] {
        IDLE,
        DRIVE_A,
        WAIT_DONE,
        CLEAR,
        OUT
    } state_t;

    // CLEAR counts up to CLR_CYC inclusive, so it needs CLR_CYC+1 distinct values
    function automatic int cnt_width(input int timeout, input int a_hold, input int clr_cyc);
        int m;
        m = timeout;
        if (a_hold > m) m = a_hold;
        if (clr_cyc + 1 > m) m = clr_cyc + 1;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/mul_operand_sequencer_timer.sv
// Shared phase/timeout up-counter with synchronous load-zero and terminal compare.
module mul_seq_timer
    import mul_pkg::*;
#(
    parameter int CW = 6
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic          en,
    input  logic [CW-1:0] term,
    output logic [CW-1:0] count,
    output logic          tc
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= '0;
        end else if (en) begin
            count <= count + CW'(1);
        end
    end

    assign tc = (count == term);

endmodule

// File: rtl/mul_operand_sequencer.sv
// Feeds an operand pair to the repeated-addition multiplier over its shared bus,
// waits for done (or times out), clears the multiplier and hands back the product.
//
//   state     | meaning
//   IDLE      | in_ready high, waiting for an operand pair
//   DRIVE_A   | A on mul_bus for A_HOLD cycles, start pulse in the first
//   WAIT_DONE | B on mul_bus, waiting for mul_done or timeout
//   CLEAR     | mul_clr for CLR_CYC cycles, then one release cycle
//   OUT       | result presented until out_ready
module mul_operand_sequencer
    import mul_pkg::*;
#(
    parameter int W       = MUL_W,
    parameter int A_HOLD  = 2,
    parameter int TIMEOUT = 64,
    parameter int CLR_CYC = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_a,
    input  logic [W-1:0] in_b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_prod,
    output logic         out_err,
    output logic         mul_start,
    output logic [W-1:0] mul_bus,
    output logic         mul_clr,
    input  logic         mul_done,
    input  logic [W-1:0] mul_prod
);

    localparam int CW = cnt_width(TIMEOUT, A_HOLD, CLR_CYC);

    state_t         state, state_nxt;
    logic [W-1:0]   a_q, b_q, a_nxt, b_nxt;
    logic [W-1:0]   out_prod_nxt, mul_bus_nxt;
    logic           out_err_nxt, in_ready_nxt, out_valid_nxt, mul_start_nxt, mul_clr_nxt;
    logic [CW-1:0]  cnt, term;
    logic           tc, load, en;

    mul_seq_timer #(.CW(CW)) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (load),
        .en    (en),
        .term  (term),
        .count (cnt),
        .tc    (tc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt    = state;
        a_nxt        = a_q;
        b_nxt        = b_q;
        out_prod_nxt = out_prod;
        out_err_nxt  = out_err;
        term         = '0;
        case (state)
            IDLE: begin
                if (in_valid && in_ready) begin
                    a_nxt     = in_a;
                    b_nxt     = in_b;
                    state_nxt = DRIVE_A;
                end
            end
            DRIVE_A: begin
                term = CW'(A_HOLD - 1);
                if (tc) state_nxt = WAIT_DONE;
            end
            WAIT_DONE: begin
                term = CW'(TIMEOUT - 1);
                // done takes priority over the final timeout cycle
                if (mul_done) begin
                    out_prod_nxt = mul_prod;
                    out_err_nxt  = 1'b0;
                    state_nxt    = CLEAR;
                end else if (tc) begin
                    out_prod_nxt = '0;
                    out_err_nxt  = 1'b1;
                    state_nxt    = CLEAR;
                end
            end
            CLEAR: begin
                term = CW'(CLR_CYC);
                if (tc) state_nxt = OUT;
            end
            OUT: begin
                if (out_valid && out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase

        in_ready_nxt  = (state_nxt == IDLE);
        out_valid_nxt = (state_nxt == OUT);
        mul_start_nxt = (state == IDLE) && (state_nxt == DRIVE_A);
        mul_clr_nxt   = (state_nxt == CLEAR) &&
                        ((state != CLEAR) || ((cnt + CW'(1)) < CW'(CLR_CYC)));
        case (state_nxt)
            DRIVE_A:   mul_bus_nxt = a_nxt;
            WAIT_DONE: mul_bus_nxt = b_nxt;
            default:   mul_bus_nxt = '0;
        endcase
    end

    assign load = (state_nxt != state);
    assign en   = (state == DRIVE_A) || (state == WAIT_DONE) || (state == CLEAR);

    // outputs registered from next-state decode so no input reaches an output combinationally
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q       <= '0;
            b_q       <= '0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_prod  <= '0;
            out_err   <= 1'b0;
            mul_start <= 1'b0;
            mul_bus   <= '0;
            mul_clr   <= 1'b1;
        end else begin
            a_q       <= a_nxt;
            b_q       <= b_nxt;
            in_ready  <= in_ready_nxt;
            out_valid <= out_valid_nxt;
            out_prod  <= out_prod_nxt;
            out_err   <= out_err_nxt;
            mul_start <= mul_start_nxt;
            mul_bus   <= mul_bus_nxt;
            mul_clr   <= mul_clr_nxt;
        end
    end

endmodule
